// File: rtl/cla_seq_subtractor_if.sv
// Valid/ready stream bundle for the nibble-serial subtractor: operand request side
// and result response side, plus the busy status flag.
interface cla_seq_subtractor_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf, busy
    );
endinterface

// File: rtl/cla_seq_subtractor.sv
// Multi-cycle subtractor d = a - b - bin, one 4-bit carry-lookahead slice per clock
// computing a + ~b + ~bin, behind a valid/ready stream.
module cla_seq_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input logic                clk,
    input logic                rst_n,
    cla_seq_subtractor_if.slave bus
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             carry_q, carry_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [3:0] an, nb, g, p, sum;
    logic [4:0] c;

    // Lookahead slice on the nibble selected by idx_q.
    always_comb begin
        an   = a_q[{idx_q, 2'b00} +: 4];
        nb   = ~b_q[{idx_q, 2'b00} +: 4];
        g    = an & nb;
        p    = an ^ nb;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        carry_d = carry_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = ~bus.bin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                d_d[{idx_q, 2'b00} +: 4] = sum;
                carry_d = c[4];
                idx_d   = IW'(idx_q + 1'b1);
                if (idx_q == LAST) begin
                    bout_d  = ~c[4];
                    ovf_d   = c[4] ^ c[3];
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_seq_subtractor.sv
// Scoreboard bench for cla_seq_subtractor: a 16-bit and a 4-bit instance checked
// against an integer model of a - b - bin.
module tb_cla_seq_subtractor;
    typedef struct {
        logic [31:0] d;
        bit          bout;
        bit          ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t q16[$];
    exp_t q4[$];

    cla_seq_subtractor_if #(.WIDTH(16)) if16 ();
    cla_seq_subtractor_if #(.WIDTH(4))  if4 ();

    cla_seq_subtractor #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    cla_seq_subtractor #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input bit bin);
        exp_t   r;
        longint m, ua, ub, diff, sa, sb, sr;
        m    = longint'(1) << w;
        ua   = longint'(a) & (m - 1);
        ub   = longint'(b) & (m - 1);
        diff = ua - ub - longint'(bin);
        r.bout = (diff < 0);
        r.d    = 32'(diff & (m - 1));
        sa   = (ua >= m / 2) ? ua - m : ua;
        sb   = (ub >= m / 2) ? ub - m : ub;
        sr   = sa - sb - longint'(bin);
        r.ovf  = (sr < -(m / 2)) || (sr >= m / 2);
        return r;
    endfunction

    // Result side: pop and compare whenever a handshake is about to complete.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if16.out_valid && if16.out_ready) begin
            if (q16.size() == 0) check("sb16_empty", 32'd1, 32'd0);
            else begin
                e = q16.pop_front();
                check("d16", {16'd0, if16.d}, e.d);
                check("bout16", {31'd0, if16.bout}, {31'd0, e.bout});
                check("ovf16", {31'd0, if16.ovf}, {31'd0, e.ovf});
            end
        end
        if (rst_n && if4.out_valid && if4.out_ready) begin
            if (q4.size() == 0) check("sb4_empty", 32'd1, 32'd0);
            else begin
                e = q4.pop_front();
                check("d4", {28'd0, if4.d}, e.d);
                check("bout4", {31'd0, if4.bout}, {31'd0, e.bout});
                check("ovf4", {31'd0, if4.ovf}, {31'd0, e.ovf});
            end
        end
    end

    // All drive tasks start and end at posedge + #1.
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input bit bin);
        int n = 0;
        while (!if16.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready16_wait", {31'd0, if16.in_ready}, 32'd1);
        if16.a = a; if16.b = b; if16.bin = bin; if16.in_valid = 1'b1;
        q16.push_back(model(16, {16'd0, a}, {16'd0, b}, bin));
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input bit bin);
        int n = 0;
        while (!if4.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready4_wait", {31'd0, if4.in_ready}, 32'd1);
        if4.a = a; if4.b = b; if4.bin = bin; if4.in_valid = 1'b1;
        q4.push_back(model(4, {28'd0, a}, {28'd0, b}, bin));
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q16.size() != 0 || q4.size() != 0 || !if16.in_ready || !if4.in_ready)
               && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain16", q16.size(), 32'd0);
        check("drain4", q4.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, if16.in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, if16.out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, if16.busy}, 32'd0);
        check({tag, "_d"}, {16'd0, if16.d}, 32'd0);
        check({tag, "_bout"}, {31'd0, if16.bout}, 32'd0);
        check({tag, "_ovf"}, {31'd0, if16.ovf}, 32'd0);
    endtask

    initial begin
        exp_t e;
        int   edges;
        int   n;
        int   cnt;
        logic [3:0] va[7] = '{4'd6, 4'd14, 4'd10, 4'd3, 4'd15, 4'd15, 4'd0};
        logic [3:0] vb[7] = '{4'd3, 4'd12, 4'd5, 4'd3, 4'd1, 4'd15, 4'd0};
        bit         vc[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.bin = 1'b0; if16.out_ready = 1'b1;
        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0; if4.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic op with latency measured from the accept edge.
        if16.a = 16'h0009; if16.b = 16'h0003; if16.bin = 1'b0; if16.in_valid = 1'b1;
        q16.push_back(model(16, 32'h9, 32'h3, 1'b0));
        edges = 0;
        do begin
            @(posedge clk); #1;
            if16.in_valid = 1'b0;
            edges++;
        end while (!if16.out_valid && edges < 20);
        check("latency", edges, 32'd5);
        check("basic_d", {16'd0, if16.d}, 32'h6);

        send16(16'h0000, 16'h0001, 1'b0);
        send16(16'h8000, 16'h0001, 1'b0);
        send16(16'hFFFF, 16'hFFFF, 1'b1);
        send16(16'h1234, 16'h1234, 1'b0);
        send16(16'h7FFF, 16'hFFFF, 1'b0);
        for (int i = 0; i < 20; i++) send16(16'($urandom), 16'($urandom), 1'($urandom));
        drain();

        // Backpressure in DONE with operand inputs wiggling.
        if16.out_ready = 1'b0;
        send16(16'h5555, 16'h1111, 1'b1);
        e = model(16, 32'h5555, 32'h1111, 1'b1);
        n = 0;
        while (!if16.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_reach", {31'd0, if16.out_valid}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("stall_valid", {31'd0, if16.out_valid}, 32'd1);
            check("stall_d", {16'd0, if16.d}, e.d);
            check("stall_bout", {31'd0, if16.bout}, {31'd0, e.bout});
            check("stall_ovf", {31'd0, if16.ovf}, {31'd0, e.ovf});
            check("stall_in_ready", {31'd0, if16.in_ready}, 32'd0);
            if16.a = 16'($urandom); if16.b = 16'($urandom); if16.bin = 1'($urandom);
            if16.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        if16.in_valid = 1'b0;
        check("stall_d_end", {16'd0, if16.d}, e.d);
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", {31'd0, if16.in_ready}, 32'd1);
        check("release_out_valid", {31'd0, if16.out_valid}, 32'd0);
        check("release_d_kept", {16'd0, if16.d}, e.d);
        check("release_sb", q16.size(), 32'd0);

        // Reset mid-RUN at nibble index 2.
        send16(16'hA5A5, 16'h0F0F, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        check("midrun_busy", {31'd0, if16.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        q16.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (if16.out_valid) cnt++;
            @(posedge clk); #1;
        end
        check("midrun_no_out", cnt, 32'd0);
        send16(16'h1000, 16'h0001, 1'b1);
        drain();

        // Narrow build, back-to-back vectors.
        for (int i = 0; i < 7; i++) send4(va[i], vb[i], vc[i]);
        for (int i = 0; i < 10; i++) send4(4'($urandom), 4'($urandom), 1'($urandom));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
